// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO.
// Frame format and bit period are latched per frame at pop time.
module uart_tx_fifo #(
  parameter int MAX_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MAX_WIDTH-1:0]          P_Data,
  input  logic                          Data_Valid,
  output logic                          Data_Ready,
  input  logic [1:0]                    Data_Len,
  input  logic                          Parity_EN,
  input  logic                          Parity_type,
  input  logic                          Stop2,
  input  logic [PRESCALE_W-1:0]         Prescale,
  output logic                          TX_Out,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic [MAX_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  logic [MAX_WIDTH-1:0]  head, mask;

  logic [PRESCALE_W-1:0] cnt, cnt_n;
  logic [PRESCALE_W-1:0] p_max, p_max_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [2:0]            last_bit, last_bit_n;
  logic                  stop_idx, stop_idx_n;
  logic                  stop2_q, stop2_n;
  logic                  par_en_q, par_en_n;
  logic                  par_q, par_n;
  logic [MAX_WIDTH-1:0]  sh, sh_n;
  logic                  tick, tx_n;

  assign full       = (FIFO_Count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (FIFO_Count == '0);
  assign Data_Ready = rst_n && !full;
  assign push       = Data_Valid && Data_Ready;
  assign head       = mem[rd_ptr];
  assign Busy       = (state != IDLE);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++)
      mask[i] = (i < (int'(Data_Len) + 5));
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    sh_n       = sh;
    p_max_n    = p_max;
    last_bit_n = last_bit;
    stop2_n    = stop2_q;
    par_en_n   = par_en_q;
    par_n      = par_q;
    pop        = 1'b0;
    tx_n       = 1'b1;
    tick       = (cnt == p_max);

    if (state != IDLE)
      cnt_n = tick ? '0 : cnt + 1'b1;

    unique case (state)
      IDLE: state_n = IDLE;
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (tick) begin
          sh_n = sh >> 1;
          if (bit_idx == last_bit) begin
            state_n    = par_en_q ? PARITY : STOP;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n    = STOP;
          stop_idx_n = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_idx == stop2_q)
            state_n = IDLE;
          else
            stop_idx_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Heading to IDLE with work queued: chain straight into START
    if (state_n == IDLE && !empty) begin
      pop        = 1'b1;
      state_n    = START;
      cnt_n      = '0;
      sh_n       = head;
      p_max_n    = (Prescale == '0) ? '0 : Prescale - 1'b1;
      last_bit_n = {1'b0, Data_Len} + 3'd4;
      stop2_n    = Stop2;
      par_en_n   = Parity_EN;
      par_n      = (^(head & mask)) ^ Parity_type;
    end

    unique case (1'b1)
      (state_n == START):  tx_n = 1'b0;
      (state_n == DATA):   tx_n = sh_n[0];
      (state_n == PARITY): tx_n = par_n;
      default:             tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= P_Data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      sh         <= '0;
      p_max      <= '0;
      last_bit   <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      TX_Out     <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_Count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      stop_idx   <= stop_idx_n;
      sh         <= sh_n;
      p_max      <= p_max_n;
      last_bit   <= last_bit_n;
      stop2_q    <= stop2_n;
      par_en_q   <= par_en_n;
      par_q      <= par_n;
      TX_Out     <= tx_n;
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      FIFO_Count <= FIFO_Count + (AW+1)'(push)
                    - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected frames queued at push time,
// a monitor pops and checks the serial line cycle by cycle.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  P_Data;
  logic        Data_Valid;
  logic        Data_Ready;
  logic [1:0]  Data_Len;
  logic        Parity_EN;
  logic        Parity_type;
  logic        Stop2;
  logic [15:0] Prescale;
  logic        TX_Out;
  logic        Busy;
  logic [2:0]  FIFO_Count;

  uart_tx_fifo #(
    .MAX_WIDTH(8),
    .FIFO_DEPTH(4),
    .PRESCALE_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .P_Data(P_Data),
    .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready),
    .Data_Len(Data_Len),
    .Parity_EN(Parity_EN),
    .Parity_type(Parity_type),
    .Stop2(Stop2),
    .Prescale(Prescale),
    .TX_Out(TX_Out),
    .Busy(Busy),
    .FIFO_Count(FIFO_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string bits;
    int    p;
    bit    b2b;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_active = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_exp(input string b, input int p, input bit b2b);
    frame_t f;
    f.bits = b;
    f.p    = p;
    f.b2b  = b2b;
    exp_q.push_back(f);
  endtask

  task automatic push_word(input logic [7:0] d, input string b,
                           input int p, input bit b2b);
    @(negedge clk);
    P_Data     = d;
    Data_Valid = 1'b1;
    add_exp(b, p, b2b);
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0 && !mon_active && !Busy && FIFO_Count == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, ok, 1);
  endtask

  // Monitor: one expected frame per queue entry
  initial begin : monitor
    frame_t f;
    bit found;
    bit e;
    bit bad;
    logic [1:0] act;
    int fi = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0 && rst_n) begin
        f = exp_q.pop_front();
        mon_active = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 600; w++) begin
          if (TX_Out === 1'b0) begin
            found = 1'b1;
            break;
          end
          if (f.b2b)
            break;
          @(negedge clk);
        end
        check($sformatf("frame%0d_start", fi), found, 1);
        if (found) begin
          for (int i = 0; i < f.bits.len(); i++) begin
            e = (f.bits[i] == "1");
            bad = 1'b0;
            act = {1'b1, e};
            for (int c = 0; c < f.p; c++) begin
              if (!(i == 0 && c == 0))
                @(negedge clk);
              if (!bad && (TX_Out !== e || Busy !== 1'b1)) begin
                bad = 1'b1;
                act = {Busy, TX_Out};
              end
            end
            check($sformatf("frame%0d_bit%0d busy,tx", fi, i),
                  32'(act), {30'd0, 1'b1, e});
          end
        end
        fi++;
        mon_active = 1'b0;
      end
    end
  end

  string bp_bits [6] = '{"0100000001", "0010000001", "0001000001",
                         "0000100001", "0000010001", "0000001001"};
  logic [7:0] bp_words [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

  initial begin : stim
    int nb;
    int k;
    int cyc;
    int acc5;
    bit stale;
    rst_n       = 1'b0;
    Data_Valid  = 1'b0;
    P_Data      = '0;
    Data_Len    = 2'b11;
    Parity_EN   = 1'b0;
    Parity_type = 1'b0;
    Stop2       = 1'b0;
    Prescale    = 16'd4;
    repeat (3) @(negedge clk);
    check("rst_tx", TX_Out, 1);
    check("rst_busy", Busy, 0);
    check("rst_count", FIFO_Count, 0);
    check("rst_ready", Data_Ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", Data_Ready, 1);

    // Basic 8E1 frame, P=4
    Prescale  = 16'd4;
    Data_Len  = 2'b11;
    Parity_EN = 1'b1;
    Parity_type = 1'b0;
    Stop2     = 1'b0;
    @(negedge clk);
    P_Data     = 8'hA5;
    Data_Valid = 1'b1;
    add_exp("01010010101", 4, 1'b0);
    @(negedge clk);
    Data_Valid = 1'b0;
    check("basic_tx_at_push_edge", TX_Out, 1);
    check("basic_count_after_push", FIFO_Count, 1);
    @(negedge clk);
    check("basic_tx_low_next", TX_Out, 0);
    nb = 0;
    while (Busy && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    check("basic_busy_cycles", nb, 44);
    wait_idle("idle_basic");

    // 5O2 frame, upper bits ignored
    Prescale    = 16'd2;
    Data_Len    = 2'b00;
    Parity_EN   = 1'b1;
    Parity_type = 1'b1;
    Stop2       = 1'b1;
    push_word(8'hFF, "011111011", 2, 1'b0);
    wait_idle("idle_short");

    // Prescale 0 acts as 1
    Prescale  = 16'd0;
    Data_Len  = 2'b11;
    Parity_EN = 1'b0;
    Stop2     = 1'b0;
    push_word(8'h3C, "0001111001", 1, 1'b0);
    wait_idle("idle_p0");

    // Backpressure with Data_Valid held high
    Prescale  = 16'd10;
    Data_Len  = 2'b11;
    Parity_EN = 1'b0;
    Stop2     = 1'b0;
    k = 0;
    cyc = 0;
    acc5 = -1;
    while (k < 6 && cyc < 400) begin
      @(negedge clk);
      if (cyc == 5) begin
        check("bp_ready_low", Data_Ready, 0);
        check("bp_count_full", FIFO_Count, 4);
      end
      P_Data     = bp_words[k];
      Data_Valid = 1'b1;
      if (Data_Ready) begin
        add_exp(bp_bits[k], 10, k != 0);
        if (k == 5)
          acc5 = cyc;
        k++;
      end
      cyc++;
    end
    @(negedge clk);
    Data_Valid = 1'b0;
    check("bp_sixth_accept_cycle", acc5, 102);
    wait_idle("idle_bp");

    // Config change during frame 1
    Prescale    = 16'd3;
    Data_Len    = 2'b11;
    Parity_EN   = 1'b1;
    Parity_type = 1'b0;
    Stop2       = 1'b0;
    push_word(8'h5A, "00101101001", 3, 1'b0);
    push_word(8'h0F, "01111001", 3, 1'b1);
    Data_Len  = 2'b01;
    Parity_EN = 1'b0;
    wait_idle("idle_cfg");

    // Reset mid-frame during data bit 3
    Prescale  = 16'd4;
    Data_Len  = 2'b11;
    Parity_EN = 1'b0;
    Stop2     = 1'b0;
    @(negedge clk);
    P_Data     = 8'h00;
    Data_Valid = 1'b1;
    repeat (3) @(negedge clk);
    Data_Valid = 1'b0;
    repeat (15) @(negedge clk);
    check("rstmid_pre_tx", TX_Out, 0);
    check("rstmid_pre_count", FIFO_Count, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_tx", TX_Out, 1);
    check("rstmid_busy", Busy, 0);
    check("rstmid_count", FIFO_Count, 0);
    check("rstmid_ready", Data_Ready, 0);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (TX_Out !== 1'b1 || Busy !== 1'b0)
        stale = 1'b1;
    end
    check("rstmid_no_stale", stale, 0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO. Frame format is configurable at run time: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits. Bit period is set by a programmable clock prescaler. It sits between the system-side byte producer and the serial line, and sends queued words back-to-back without CPU pacing.

Parameters:
MAX_WIDTH, 8, width of P_Data; runtime data length is never larger than this.
FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2, ≥2.
PRESCALE_W, 16, width of the Prescale input.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
P_Data  input  MAX_WIDTH  parallel word to transmit
Data_Valid  input  1  producer offers P_Data this cycle
Data_Ready  output  1  FIFO can accept a word; high when not full and rst_n high
Data_Len  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8
Parity_EN  input  1  1 = append parity bit
Parity_type  input  1  0 = even, 1 = odd
Stop2  input  1  1 = two stop bits, 0 = one
Prescale  input  PRESCALE_W  clk cycles per bit; 0 is treated as 1
TX_Out  output  1  registered serial line; idles high
Busy  output  1  frame in progress
FIFO_Count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clk edge):
  - TX_Out=1, Busy=0, FIFO_Count=0, FIFO emptied, FSM to IDLE.
  - Data_Ready=0 while rst_n is low.
  - A frame in progress is abandoned immediately, with no stop bit.
- Push:
  - A word is accepted on an edge where Data_Valid && Data_Ready.
  - Data_Ready = !full only; a push on a full FIFO is not possible, even if a pop happens the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Frame start:
  - The FSM is in IDLE, or on the final cycle of the last stop bit, and the FIFO is non-empty.
  - On that edge it pops the head word and latches Data_Len, Parity_EN, Parity_type, Stop2 and Prescale for the whole frame.
  - Changes to these inputs mid-frame have no effect until the next frame.
- FSM states: IDLE → START → DATA → PARITY (skipped if Parity_EN=0) → STOP → IDLE or START.
- Bit timing:
  - Each state/bit holds TX_Out for exactly max(Prescale,1) cycles, counted by a bit-period counter.
  - DATA sends Data_Len+5 bits, LSB first. Bits above the selected length are ignored.
  - STOP lasts 1 or 2 bit periods.
- Parity: XOR of the transmitted data bits only. Even: bit = XOR. Odd: bit = ~XOR.
- Line levels: TX_Out = 0 in START, data or parity bit in DATA/PARITY, 1 in STOP and IDLE.
- Latency: a word pushed into an empty FIFO while IDLE is popped on the next edge; TX_Out goes low one cycle after the push edge.
- Back-to-back frames: if the FIFO is non-empty at the end of STOP, START follows immediately with zero idle cycles, and Busy stays high.
- Busy is 1 from the first START cycle to the last STOP cycle inclusive, and 0 in IDLE.
- Frame length in cycles = P × (1 + N + Parity_EN + 1 + Stop2), where P = max(Prescale,1) and N = Data_Len+5.
- FIFO pointers wrap modulo FIFO_DEPTH. FIFO_Count is exact; it never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Basic frame. Prescale=4, Data_Len=11, Parity_EN=1 even, Stop2=0, push 0xA5 while idle → TX_Out sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles (44 cycles). Busy high for exactly 44 cycles. First low cycle is one cycle after the push.
- Short odd frame. Prescale=2, Data_Len=00, Parity_EN=1 odd, Stop2=1, P_Data=0xFF → bits 0,1,1,1,1,1,0,1,1 (18 cycles); P_Data[7:5] ignored.
- FIFO full / backpressure. Prescale=10, FIFO_DEPTH=4, Data_Valid held high with 6 distinct words:
  - 5 accepted, then Data_Ready=0 and FIFO_Count=4.
  - Data_Ready returns high the cycle after the second frame is popped.
  - All 6 words are transmitted in order with no gaps between frames.
- Prescale=0, Parity_EN=0, Data_Len=11, P_Data=0x3C → 10-cycle frame, 1 cycle per bit: 0,0,0,1,1,1,1,0,0,1.
- Mid-frame config change. Change Data_Len and Parity_EN during frame 1 → frame 1 keeps its latched format, and frame 2 uses the new one.
- Reset mid-frame. Assert rst_n=0 during the DATA bit 3 edge with 2 words queued → next cycle TX_Out=1, Busy=0, FIFO_Count=0. After release, no stale word is transmitted.
